// File: rtl/rename_freelist_ctrl.sv
// ---------------------------------------------------------------------------
// rename_freelist_ctrl
//
// Physical-register free list for the rename stage. After reset the list is
// filled with tags NUM_ARCH..NUM_PHYS-1 over DEPTH cycles (INIT), then the
// block grants at most one tag per cycle, takes one tag back per cycle from
// commit, and can roll the allocation point back to a single checkpoint.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   reset         asynchronous, active-low reset
//   alloc_req     rename stage asks for one tag this cycle
//   alloc_gnt     combinational grant; the tag is consumed on a granted edge
//   alloc_preg    tag at the head of the list (valid while alloc_gnt=1)
//   free_valid    commit returns one tag
//   free_preg     tag being returned
//   ckpt_save     snapshot the allocation point
//   ckpt_restore  roll allocation back to the snapshot (wins over save)
//   ready         initialisation finished
//   free_count    number of tags currently in the list
//   empty         free_count == 0
//   ovf_err       sticky: a tag was returned while the list was full
//
// Optional feature: define FREELIST_BYPASS_EN to let a tag returned while the
// list is empty be granted in the same cycle without touching the list.
// ---------------------------------------------------------------------------
module rename_freelist_ctrl #(
    parameter int NUM_PHYS = 32,
    parameter int NUM_ARCH = 14,
    parameter int PREG_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              free_valid,
    input  logic [PREG_W-1:0] free_preg,
    input  logic              ckpt_save,
    input  logic              ckpt_restore,
    output logic              ready,
    output logic [PREG_W:0]   free_count,
    output logic              empty,
    output logic              ovf_err
);

    localparam int DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PREG_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    // DEPTH is not a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  fill_idx_q, fill_idx_d;
    logic [PTR_W-1:0]  ckpt_head_q, ckpt_head_d;
    logic [CNT_W-1:0]  free_count_q, free_count_d;
    logic [CNT_W-1:0]  alloc_since_ckpt_q, alloc_since_ckpt_d;
    logic              ovf_err_q, ovf_err_d;

    logic [PREG_W-1:0] list_q [DEPTH];

    logic              bypass_avail;
    logic              bypass_take;
    logic              pop;
    logic              push;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_addr;
    logic [PREG_W-1:0] wr_data;

    assign ready      = (state_q == ST_READY);
    assign free_count = free_count_q;
    assign empty      = (free_count_q == '0);
    assign ovf_err    = ovf_err_q;

`ifdef FREELIST_BYPASS_EN
    // A tag returned into an empty list can go straight to the rename stage.
    assign bypass_avail = ready & free_valid & (free_count_q == '0);
`else
    assign bypass_avail = 1'b0;
`endif

    assign alloc_gnt   = ready & alloc_req & ~ckpt_restore
                       & ((free_count_q != '0) | bypass_avail);
    assign bypass_take = alloc_gnt & bypass_avail;
    assign pop         = alloc_gnt & ~bypass_take;
    // A full list drops the returned tag (and flags it); a bypassed tag never
    // enters the list.
    assign push        = ready & free_valid & (free_count_q != DEPTH_CNT) & ~bypass_take;

    always_comb begin
        alloc_preg = bypass_avail ? free_preg : list_q[head_q];
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the branches below leaves a variable unassigned (no latch).
        state_d            = state_q;
        head_d             = head_q;
        tail_d             = tail_q;
        fill_idx_d         = fill_idx_q;
        ckpt_head_d        = ckpt_head_q;
        free_count_d       = free_count_q;
        alloc_since_ckpt_d = alloc_since_ckpt_q;
        ovf_err_d          = ovf_err_q;
        wr_en              = 1'b0;
        wr_addr            = tail_q;
        wr_data            = free_preg;

        case (state_q)
            ST_INIT: begin
                // Fill one slot per cycle with the unmapped tags; tail tracks
                // the fill index and wraps back to 0 on the last write.
                wr_en        = 1'b1;
                wr_addr      = fill_idx_q;
                wr_data      = PREG_W'(NUM_ARCH) + PREG_W'(fill_idx_q);
                fill_idx_d   = ptr_inc(fill_idx_q);
                tail_d       = ptr_inc(tail_q);
                free_count_d = free_count_q + CNT_W'(1);
                if (fill_idx_q == LAST_PTR) begin
                    state_d = ST_READY;
                end
            end

            ST_READY: begin
                if (push) begin
                    wr_en  = 1'b1;
                    tail_d = ptr_inc(tail_q);
                end
                if (ready & free_valid & (free_count_q == DEPTH_CNT)) begin
                    ovf_err_d = 1'b1;
                end
                if (pop) begin
                    head_d = ptr_inc(head_q);
                end
                free_count_d = free_count_q + CNT_W'(push) - CNT_W'(pop);

                if (ckpt_restore) begin
                    // No grant happens on a restore cycle; frees still land.
                    head_d             = ckpt_head_q;
                    free_count_d       = free_count_q + CNT_W'(push) + alloc_since_ckpt_q;
                    alloc_since_ckpt_d = '0;
                end else if (ckpt_save) begin
                    // The checkpoint sits after this cycle's grant, if any.
                    ckpt_head_d        = head_d;
                    alloc_since_ckpt_d = '0;
                end else if (alloc_gnt) begin
                    alloc_since_ckpt_d = alloc_since_ckpt_q + CNT_W'(1);
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= ST_INIT;
            head_q             <= '0;
            tail_q             <= '0;
            fill_idx_q         <= '0;
            ckpt_head_q        <= '0;
            free_count_q       <= '0;
            alloc_since_ckpt_q <= '0;
            ovf_err_q          <= 1'b0;
        end else begin
            state_q            <= state_d;
            head_q             <= head_d;
            tail_q             <= tail_d;
            fill_idx_q         <= fill_idx_d;
            ckpt_head_q        <= ckpt_head_d;
            free_count_q       <= free_count_d;
            alloc_since_ckpt_q <= alloc_since_ckpt_d;
            ovf_err_q          <= ovf_err_d;
        end
    end

    // NOTE: the list storage has no reset; INIT rewrites every slot before
    // any entry can be read as valid, so plain RAM is enough.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            list_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rename_freelist_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for rename_freelist_ctrl.
// A driver applies one set of inputs per cycle, steps a queue-based reference
// model of the free list and pushes the expected outputs for that cycle into
// a scoreboard queue. A monitor on the falling edge pops one entry per cycle
// and compares it with what the DUT presents.
// ---------------------------------------------------------------------------
module tb_rename_freelist_ctrl;

    localparam int NUM_PHYS = 32;
    localparam int NUM_ARCH = 14;
    localparam int PREG_W   = 5;
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH;

`ifdef FREELIST_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              alloc_req;
    logic              alloc_gnt;
    logic [PREG_W-1:0] alloc_preg;
    logic              free_valid;
    logic [PREG_W-1:0] free_preg;
    logic              ckpt_save;
    logic              ckpt_restore;
    logic              ready;
    logic [PREG_W:0]   free_count;
    logic              empty;
    logic              ovf_err;

    rename_freelist_ctrl #(
        .NUM_PHYS (NUM_PHYS),
        .NUM_ARCH (NUM_ARCH),
        .PREG_W   (PREG_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_preg   (alloc_preg),
        .free_valid   (free_valid),
        .free_preg    (free_preg),
        .ckpt_save    (ckpt_save),
        .ckpt_restore (ckpt_restore),
        .ready        (ready),
        .free_count   (free_count),
        .empty        (empty),
        .ovf_err      (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit ready;
        bit gnt;
        int count;
        bit empty;
        bit ovf;
        bit chk_preg;
        int preg;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the free list as an ordered queue of tags, plus the
    // ordered list of tags granted since the last checkpoint.
    int m_init_left;
    int m_list[$];
    int m_since[$];
    bit m_ovf;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_step(input bit req, input bit fv, input int fp,
                              input bit save, input bit rest, input bit rst_low,
                              output exp_t e);
        int cnt;
        int tag;
        bit byp;
        e.ready    = 1'b0;
        e.gnt      = 1'b0;
        e.count    = 0;
        e.empty    = 1'b1;
        e.ovf      = 1'b0;
        e.chk_preg = 1'b0;
        e.preg     = 0;
        if (rst_low) begin
            m_init_left = DEPTH;
            m_list.delete();
            m_since.delete();
            m_ovf = 1'b0;
            return;
        end
        if (m_init_left > 0) begin
            e.count = DEPTH - m_init_left;
            e.empty = (e.count == 0);
            m_init_left--;
            if (m_init_left == 0) begin
                for (int k = 0; k < DEPTH; k++) m_list.push_back(NUM_ARCH + k);
            end
            return;
        end
        cnt        = m_list.size();
        byp        = BYPASS && (cnt == 0) && fv;
        e.ready    = 1'b1;
        e.count    = cnt;
        e.empty    = (cnt == 0);
        e.ovf      = m_ovf;
        e.gnt      = req && !rest && (cnt > 0 || byp);
        e.chk_preg = (cnt > 0) || byp;
        e.preg     = byp ? fp : ((cnt > 0) ? m_list[0] : 0);
        if (e.gnt) begin
            tag = byp ? fp : m_list.pop_front();
            m_since.push_back(tag);
        end
        if (fv && !(e.gnt && byp)) begin
            if (cnt == DEPTH) m_ovf = 1'b1;
            else              m_list.push_back(fp);
        end
        if (rest) begin
            m_list = {m_since, m_list};
            m_since.delete();
        end else if (save) begin
            m_since.delete();
        end
    endtask

    task automatic cycle(input bit req, input bit fv, input int fp,
                         input bit save, input bit rest, input bit rst_low);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = ~rst_low;
        alloc_req    = req;
        free_valid   = fv;
        free_preg    = fp[PREG_W-1:0];
        ckpt_save    = save;
        ckpt_restore = rest;
        model_step(req, fv, fp, save, rest, rst_low, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset_and_init();
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        idle(DEPTH);
    endtask

    // Monitor: one scoreboard entry per driven cycle, compared mid-cycle.
    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("ready",      int'(ready),      int'(mon_e.ready));
            check("alloc_gnt",  int'(alloc_gnt),  int'(mon_e.gnt));
            check("free_count", int'(free_count), mon_e.count);
            check("empty",      int'(empty),      int'(mon_e.empty));
            check("ovf_err",    int'(ovf_err),    int'(mon_e.ovf));
            if (mon_e.chk_preg) check("alloc_preg", int'(alloc_preg), mon_e.preg);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
        $fatal(1, "timeout");
    end

    int  r_fp;
    bit  r_req, r_fv, r_save, r_rest, r_rst;
    int  r_cnt;

    initial begin
        reset        = 1'b0;
        alloc_req    = 1'b0;
        free_valid   = 1'b0;
        free_preg    = '0;
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;
        m_init_left  = DEPTH;
        m_ovf        = 1'b0;

        // Reset, init, first tag visible at head.
        do_reset_and_init();
        idle(1);

        // Drain all tags in order, then request against an empty list.
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // Free into the empty list with a simultaneous request.
        cycle(1, 1, 3, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // Overflow on a full list is dropped and sticky.
        do_reset_and_init();
        cycle(0, 1, 5, 0, 0, 0);
        idle(2);

        // Checkpoint at head=2, four grants, one free, restore.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 7, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 0, 0, 0);

        // Save and restore on the same cycle as grants/frees.
        cycle(0, 1, 9, 0, 0, 0);
        cycle(1, 1, 11, 1, 0, 0);
        cycle(1, 1, 12, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 0);
        idle(1);

        // Reset in the middle of a granting stream, then check the refill.
        do_reset_and_init();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        idle(DEPTH);
        for (int i = 0; i < DEPTH + 1; i++) cycle(1, 0, 0, 0, 0, 0);

        // Randomized traffic. Frees are limited so that tags granted since the
        // checkpoint are never overwritten before a restore (the list can hold
        // at most DEPTH tags in total), except on a full list to hit overflow.
        r_rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r_cnt  = m_list.size();
            r_req  = ($urandom_range(0, 99) < 60);
            r_fv   = ($urandom_range(0, 99) < 45);
            r_fp   = int'($urandom_range(0, NUM_PHYS - 1));
            r_save = ($urandom_range(0, 99) < 8);
            r_rest = ($urandom_range(0, 99) < 6);
            if (m_init_left == 0 && !r_rst
                && !((r_cnt + m_since.size() < DEPTH) || (r_cnt == DEPTH)))
                r_fv = 1'b0;
            r_rst = (!r_rst) && ($urandom_range(0, 399) == 0);
            cycle(r_req, r_fv, r_fp, r_save, r_rest, r_rst);
        end
        idle(2);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
